// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for the universal shift register: step controls,
// serial/parallel inputs, burst request and the register/status outputs.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d_par;
  logic             sin_lsb;
  logic             sin_msb;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d_par, sin_lsb, sin_msb, start, burst_len,
    input  q, sout_msb, sout_lsb, busy, done
  );

  modport slave (
    input  en, mode, d_par, sin_lsb, sin_msb, start, burst_len,
    output q, sout_msb, sout_lsb, busy, done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with eight per-cycle modes and a burst
// engine that applies N shift/rotate steps from one start pulse.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  univ_shift_reg_if.slave bus
);

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_SHL  = 3'd1,
    M_SHR  = 3'd2,
    M_ROL  = 3'd3,
    M_ROR  = 3'd4,
    M_LOAD = 3'd5,
    M_ASR  = 3'd6,
    M_CLR  = 3'd7
  } mode_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  mode_e            r_mode, w_mode_nxt;
  logic             r_done, w_done_nxt;
  mode_e            w_mode_in;
  logic             w_burst_ok;

  function automatic logic [WIDTH-1:0] f_step(
    input mode_e            m,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d,
    input logic             sl,
    input logic             sm
  );
    case (m)
      M_SHL:   f_step = {q[WIDTH-2:0], sl};
      M_SHR:   f_step = {sm, q[WIDTH-1:1]};
      M_ROL:   f_step = {q[WIDTH-2:0], q[WIDTH-1]};
      M_ROR:   f_step = {q[0], q[WIDTH-1:1]};
      M_LOAD:  f_step = d;
      M_ASR:   f_step = {q[WIDTH-1], q[WIDTH-1:1]};
      M_CLR:   f_step = '0;
      default: f_step = q;
    endcase
  endfunction

  assign w_mode_in  = mode_e'(bus.mode);
  // Only shift/rotate modes make sense repeated; anything else completes at once.
  assign w_burst_ok = (bus.burst_len != '0) &&
                      (w_mode_in inside {M_SHL, M_SHR, M_ROL, M_ROR, M_ASR});

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_burst_ok) begin
            w_mode_nxt  = w_mode_in;
            w_cnt_nxt   = bus.burst_len;
            w_state_nxt = S_RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else if (bus.en) begin
          w_q_nxt = f_step(w_mode_in, r_q, bus.d_par, bus.sin_lsb, bus.sin_msb);
        end
      end
      S_RUN: begin
        if (bus.en) begin
          w_q_nxt   = f_step(r_mode, r_q, bus.d_par, bus.sin_lsb, bus.sin_msb);
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mode  <= M_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.q        = r_q;
  assign bus.sout_msb = r_q[WIDTH-1];
  assign bus.sout_lsb = r_q[0];
  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus a randomized
// run compared cycle by cycle against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: register value, steps still owed by a burst, burst mode.
  logic [7:0] m_q    = 8'h00;
  int         m_rem  = 0;
  logic [2:0] m_mode = 3'd0;
  logic       m_done = 1'b0;

  univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] apply(input logic [2:0] m, input logic [7:0] q,
                                       input logic [7:0] d, input logic sl, input logic sm);
    case (m)
      3'd1:    return (q << 1) | {7'd0, sl};
      3'd2:    return (q >> 1) | {sm, 7'd0};
      3'd3:    return (q << 1) | (q >> 7);
      3'd4:    return (q >> 1) | (q << 7);
      3'd5:    return d;
      3'd6:    return 8'($signed(q) >>> 1);
      3'd7:    return 8'h00;
      default: return q;
    endcase
  endfunction

  function automatic bit burstable(input logic [2:0] m);
    return (m == 3'd1) || (m == 3'd2) || (m == 3'd3) || (m == 3'd4) || (m == 3'd6);
  endfunction

  task automatic compare_all(input string where);
    check({where, ".q"},        32'(bus.q),        32'(m_q));
    check({where, ".busy"},     32'(bus.busy),     32'(m_rem != 0));
    check({where, ".done"},     32'(bus.done),     32'(m_done));
    check({where, ".sout_msb"}, 32'(bus.sout_msb), 32'(m_q[7]));
    check({where, ".sout_lsb"}, 32'(bus.sout_lsb), 32'(m_q[0]));
  endtask

  // Drive one cycle's inputs, take the edge, advance the model, compare.
  task automatic cycle(input string where, input logic e, input logic [2:0] m,
                       input logic [7:0] d, input logic sl, input logic sm,
                       input logic st, input logic [3:0] len);
    bus.en = e; bus.mode = m; bus.d_par = d; bus.sin_lsb = sl; bus.sin_msb = sm;
    bus.start = st; bus.burst_len = len;
    @(posedge clk);
    if (m_rem == 0) begin
      m_done = 1'b0;
      if (st) begin
        if (len != 0 && burstable(m)) begin
          m_rem  = int'(len);
          m_mode = m;
        end else begin
          m_done = 1'b1;
        end
      end else if (e) begin
        m_q = apply(m, m_q, d, sl, sm);
      end
    end else begin
      m_done = 1'b0;
      if (e) begin
        m_q = apply(m_mode, m_q, d, sl, sm);
        m_rem--;
        if (m_rem == 0) m_done = 1'b1;
      end
    end
    #1;
    compare_all(where);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset(input string where);
    #2 rst = 1'b0;
    #1;
    m_q = 8'h00; m_rem = 0; m_done = 1'b0;
    check({where, ".q"},    32'(bus.q),    32'h0);
    check({where, ".busy"}, 32'(bus.busy), 32'h0);
    check({where, ".done"}, 32'(bus.done), 32'h0);
    #1 rst = 1'b1;
  endtask

  initial begin
    int nb;
    bus.en = 1'b0; bus.mode = 3'd0; bus.d_par = 8'h00; bus.sin_lsb = 1'b0;
    bus.sin_msb = 1'b0; bus.start = 1'b0; bus.burst_len = 4'd0;
    #2;
    compare_all("por");
    #1 rst = 1'b1;

    // Reset mid-operation with a non-zero register
    cycle("ld_a5", 1, 3'd5, 8'hA5, 0, 0, 0, 0);
    check("a5_loaded", 32'(bus.q), 32'hA5);
    mid_reset("rst_a5");

    // SHL serial-in 1,0,1,1 then hold with en=0
    cycle("clr", 1, 3'd7, 8'h00, 0, 0, 0, 0);
    cycle("shl0", 1, 3'd1, 8'h00, 1, 0, 0, 0);
    cycle("shl1", 1, 3'd1, 8'h00, 0, 0, 0, 0);
    cycle("shl2", 1, 3'd1, 8'h00, 1, 0, 0, 0);
    cycle("shl3", 1, 3'd1, 8'h00, 1, 0, 0, 0);
    check("shl_0b", 32'(bus.q), 32'h0B);
    for (int i = 0; i < 4; i++) cycle("shl_hold", 0, 3'd1, 8'h00, 1, 1, 0, 0);
    check("shl_hold_0b", 32'(bus.q), 32'h0B);

    // LOAD then ASR twice
    cycle("ld_90", 1, 3'd5, 8'h90, 0, 0, 0, 0);
    cycle("asr1", 1, 3'd6, 8'h00, 0, 0, 0, 0);
    check("asr_c8", 32'(bus.q), 32'hC8);
    cycle("asr2", 1, 3'd6, 8'h00, 0, 0, 0, 0);
    check("asr_e4", 32'(bus.q), 32'hE4);

    // Burst ROL x3 on 0x81, mode switched to CLR during RUN
    cycle("ld_81", 1, 3'd5, 8'h81, 0, 0, 0, 0);
    cycle("rol_start", 1, 3'd3, 8'h00, 0, 0, 1, 4'd3);
    check("rol_start_q", 32'(bus.q), 32'h81);
    check("rol_start_busy", 32'(bus.busy), 32'h1);
    cycle("rol_s1", 1, 3'd7, 8'h00, 0, 0, 1, 4'd3);
    check("rol_03", 32'(bus.q), 32'h03);
    cycle("rol_s2", 1, 3'd7, 8'h00, 0, 0, 0, 0);
    check("rol_06", 32'(bus.q), 32'h06);
    cycle("rol_s3", 1, 3'd7, 8'h00, 0, 0, 0, 0);
    check("rol_0c", 32'(bus.q), 32'h0C);
    check("rol_done", 32'(bus.done), 32'h1);
    check("rol_busy_fell", 32'(bus.busy), 32'h0);
    cycle("rol_after", 0, 3'd7, 8'h00, 0, 0, 0, 0);
    check("rol_done_once", 32'(bus.done), 32'h0);

    // ROR x4 on 0x01 with a two-cycle stall after the first step
    cycle("ld_01", 1, 3'd5, 8'h01, 0, 0, 0, 0);
    nb = 0;
    cycle("ror_start", 1, 3'd4, 8'h00, 0, 0, 1, 4'd4); nb += int'(bus.busy);
    cycle("ror_s1", 1, 3'd0, 8'h00, 0, 0, 0, 0);       nb += int'(bus.busy);
    cycle("ror_st1", 0, 3'd0, 8'h00, 0, 0, 0, 0);      nb += int'(bus.busy);
    cycle("ror_st2", 0, 3'd0, 8'h00, 0, 0, 0, 0);      nb += int'(bus.busy);
    check("ror_stall_80", 32'(bus.q), 32'h80);
    for (int i = 0; i < 3; i++) begin
      cycle("ror_s", 1, 3'd0, 8'h00, 0, 0, 0, 0);
      nb += int'(bus.busy);
    end
    check("ror_busy_cycles", 32'(nb), 32'd6);
    check("ror_10", 32'(bus.q), 32'h10);
    check("ror_done", 32'(bus.done), 32'h1);

    // Same burst, reset after the second step: no done afterwards
    cycle("ld_01b", 1, 3'd5, 8'h01, 0, 0, 0, 0);
    cycle("rorb_start", 1, 3'd4, 8'h00, 0, 0, 1, 4'd4);
    cycle("rorb_s1", 1, 3'd0, 8'h00, 0, 0, 0, 0);
    cycle("rorb_s2", 1, 3'd0, 8'h00, 0, 0, 0, 0);
    check("rorb_40", 32'(bus.q), 32'h40);
    mid_reset("rorb_rst");
    for (int i = 0; i < 4; i++) begin
      cycle("rorb_post", 0, 3'd0, 8'h00, 0, 0, 0, 0);
      check("rorb_no_done", 32'(bus.done), 32'h0);
    end

    // Zero-length burst, then a LOAD-mode burst request
    cycle("ld_3c", 1, 3'd5, 8'h3C, 0, 0, 0, 0);
    cycle("zl_start", 1, 3'd1, 8'h00, 1, 1, 1, 4'd0);
    check("zl_q", 32'(bus.q), 32'h3C);
    check("zl_busy", 32'(bus.busy), 32'h0);
    check("zl_done", 32'(bus.done), 32'h1);
    cycle("il_start", 1, 3'd5, 8'hFF, 1, 1, 1, 4'd5);
    check("il_q", 32'(bus.q), 32'h3C);
    check("il_busy", 32'(bus.busy), 32'h0);
    check("il_done", 32'(bus.done), 32'h1);
    cycle("il_after", 0, 3'd0, 8'h00, 0, 0, 0, 0);
    check("il_done_once", 32'(bus.done), 32'h0);

    // Randomized run with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      logic       e, st;
      logic [2:0] m;
      logic [3:0] len;
      e   = ($urandom_range(0, 9) < 8);
      st  = ($urandom_range(0, 9) == 0);
      m   = 3'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
      cycle("rnd", e, m, 8'($urandom), 1'($urandom), 1'($urandom), st, len);
      if ($urandom_range(0, 199) == 0) mid_reset("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
